// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (mid-bit sampling) feeding a small valid/ready receive FIFO.
// Optional build macro UART_RX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ((^data) ^ par) == 1'b0;
  endfunction
`endif

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_s, frame_err_s;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state, counters and shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; cnt restarts on every sample so each wait is a fixed count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!sync2_q) state_d = S_START;
        else          state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = CNT_ZERO;
          bit_d = 3'd0;
          if (sync2_q) state_d = S_IDLE;
          else         state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
          else               state_d = S_DATA;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
          else               state_d = S_DATA;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          par_d   = sync2_q;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = CNT_ZERO;
          if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
            if (even_parity_ok(shift_q, par_q)) push_s = 1'b1;
            else                                frame_err_s = 1'b1;
`else
            push_s = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        cnt_d = CNT_ZERO;
        if (sync2_q) state_d = S_IDLE;
        else         state_d = S_BREAK;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty_s, full_s, pop_s, wr_en_s;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_s   = ~empty_s & out_ready;
  assign wr_en_s = push_s & (~full_s | pop_s);

  // FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {(AW + 1){1'b0}};
      rd_ptr_q <= {(AW + 1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clock) begin
    if (wr_en_s) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = ~empty_s;
  assign frame_err = frame_err_s;
  assign overrun   = push_s & full_s & ~pop_s;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Frames are driven one bit per 16 cycles, starting #1 after a rising edge.
module tb_uart_rx_fifo;
  localparam int B = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFF = 170;
`else
  localparam int STOP_OFF = 154;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(B), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe outputs mid-cycle: pulses, valid rises and accepted bytes.
  always @(negedge clock) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    if (out_valid) valid_cnt <= valid_cnt + 1;
    if (out_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= out_valid;
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (B) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rx = 1'b1; out_ready = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {frame_err, overrun}); end
    reset = 1'b0;
    idle(5);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_byte();
    int n0, v0, f0, o0;
    out_ready = 1'b1; got_q.delete(); idle(5);
    v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt; n0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    checks++; if (rise_cyc !== n0 + STOP_OFF + 1) begin errors++; $display("FAIL a5_latency got=%0d exp=%0d", rise_cyc - n0, STOP_OFF + 1); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_cycles got=%0d exp=1", valid_cnt - v0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL a5_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", got_q[0]); end
    checks++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) begin errors++; $display("FAIL a5_no_err got=%0d exp=0", fe_cnt - f0 + ov_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0;
    out_ready = 1'b1; got_q.delete(); f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", rx_busy); end
    idle(30);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_push got=%0d exp=0", got_q.size()); end
    checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=%0d", fe_cnt, f0); end
  endtask

  task automatic test_frame_err();
    int f0, o0;
    out_ready = 1'b1; got_q.delete(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", rx_busy); end
    idle(20);
    send_frame(8'h11, 1'b1);
    idle(20);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - f0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_bytes got=%0d exp=1", got_q.size()); end
    checks++; if (got_q[0] !== 8'h11) begin errors++; $display("FAIL ferr_next_data got=%h exp=11", got_q[0]); end
    checks++; if (ov_cnt !== o0) begin errors++; $display("FAIL ferr_overrun got=%0d exp=%0d", ov_cnt, o0); end
  endtask

  task automatic test_overrun();
    int o0, f0;
    out_ready = 1'b0; got_q.delete(); o0 = ov_cnt; f0 = fe_cnt;
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1);
    idle(4);
    checks++; if (ov_cnt !== o0) begin errors++; $display("FAIL ovr_early got=%0d exp=%0d", ov_cnt, o0); end
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL ovr_head got=%b/%h exp=1/01", out_valid, out_data); end
    send_frame(8'h05, 1'b1);
    idle(4);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - o0); end
    checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL ovr_ferr got=%0d exp=%0d", fe_cnt, f0); end
    out_ready = 1'b1; idle(10); out_ready = 1'b0;
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL ovr_drain_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, got_q[i], 8'(i + 1)); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_pop();
    int o0, n0;
    logic [7:0] exp_q [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    out_ready = 1'b0; got_q.delete();
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1);
    idle(4);
    o0 = ov_cnt; n0 = cyc;
    fork
      send_frame(8'h06, 1'b1);
      begin
        repeat (STOP_OFF) @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
      end
    join
    idle(4);
    checks++; if (ov_cnt !== o0) begin errors++; $display("FAIL fullpop_overrun got=%0d exp=%0d", ov_cnt, o0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL fullpop_popped got=%0d exp=1", got_q.size()); end
    out_ready = 1'b1; idle(10); out_ready = 1'b0;
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL fullpop_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    if (n0 < 0) $display("note: cycle base %0d", n0);
  endtask

  task automatic test_reset_midframe();
    int f0;
    logic [7:0] d;
    out_ready = 1'b0; got_q.delete(); d = 8'h55;
    send_frame(8'h42, 1'b1);
    idle(4);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_prefill got=%b exp=1", out_valid); end
    f0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (6) @(posedge clock);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", rx_busy); end
    reset = 1'b1; rx = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", rx_busy); end
    idle(40);
    out_ready = 1'b1;
    send_frame(8'h77, 1'b1);
    idle(20);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rst_next_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q[0] !== 8'h77) begin errors++; $display("FAIL rst_next_data got=%h exp=77", got_q[0]); end
    checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL rst_ferr got=%0d exp=%0d", fe_cnt, f0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [3] = '{8'h00, 8'hFF, 8'h81};
    out_ready = 1'b1; got_q.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b1);
    idle(20);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    out_ready = 1'b1; got_q.delete(); f0 = fe_cnt;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(20);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h07) begin errors++; $display("FAIL par_good got=%0d/%h exp=1/07", got_q.size(), got_q[0]); end
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(20);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL par_bad_ferr got=%0d exp=1", fe_cnt - f0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL par_bad_push got=%0d exp=1", got_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a receive FIFO, placed directly upstream of the core's serial input (board pin ftdi_txd).
- Synchronises the asynchronous rx line and samples each bit at mid-bit with a clock-cycle counter.
- Pushes each good byte into a small FIFO, drained through a valid/ready handshake.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200). Must be >= 4.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of two, >= 2.

Ports:
- clock  in  1  system clock (100 MHz on ULX3S)
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- out_data  out  8  FIFO head byte; valid only while out_valid=1
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid=1 and out_ready=1
- frame_err  out  1  one-cycle pulse: stop bit sampled 0 (or parity bad, see below)
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full
- rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - Both synchroniser flops = 1.
  - FSM = IDLE; bit counter and cycle counter = 0; FIFO empty.
  - out_valid, frame_err, overrun, rx_busy = 0. out_data is don't-care while out_valid=0.
- Synchroniser: two flops. All FSM decisions use the second-flop output rs.
- Timing reference: t0 is the cycle in which the FSM in IDLE sees rs=0.
  - H = CLKS_PER_BIT/2 (integer division); B = CLKS_PER_BIT.
- IDLE:
  - rs=0 -> START, cycle counter cleared.
- START: sample rs at t0+H.
  - rs=1 -> IDLE. This is a glitch: no error and no push.
  - rs=0 -> DATA.
- DATA:
  - Bit i (i = 0..7, LSB first) is sampled at t0+H+(i+1)*B and shifted into the shift register.
  - After bit 7 -> STOP.
- STOP: sample rs at t0+H+9*B.
  - rs=1 -> push the byte and go to IDLE in the same cycle, so a new start bit is detectable from the next cycle.
  - rs=0 -> pulse frame_err, discard the byte, go to BREAK.
- BREAK:
  - Wait until rs=1, then go to IDLE.
  - A held-low line (break) produces exactly one frame_err and no further bytes.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; pointers wrap modulo 2*FIFO_DEPTH.
  - Empty: pointers equal. Full: indexes equal and MSBs differ.
  - out_data = mem[rd_idx], read combinationally.
  - Pop when out_valid & out_ready.
- Latency: a pushed byte appears with out_valid=1 in the cycle after the stop-bit sample.
- Push while full:
  - Accepted if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overrun pulses for one cycle, in the same cycle the push would have happened.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- Push into an empty FIFO: out_valid rises next cycle. There is no same-cycle bypass.
- frame_err and overrun are never asserted in the same cycle.
- Reset asserted mid-frame:
  - Partial byte discarded; all state returns to reset values the next cycle.
  - A line still low after reset is seen as a start bit and handled by the normal glitch/frame rules.
- rx_busy = 1 in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples at t0+H+9*B; STOP then samples at t0+H+10*B.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - If parity is bad but the stop bit is 1: frame_err pulses at the stop sample, the byte is discarded, and the FSM goes to IDLE (not BREAK).
- Not defined:
  - No PARITY state; behaviour is exactly 8N1 as above.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0xA5 8N1, out_ready=1 -> out_valid high one cycle with out_data=0xA5, appearing at t0+H+9*B+1 = t0+153 cycles from the start edge as seen by the FSM; no error pulses.
- Low pulse of 4 cycles on idle line -> FSM returns to IDLE, no push, frame_err=0.
- Send 0x3C with stop bit forced 0, line held low 100 cycles, then send 0x11 -> one frame_err pulse; then out_data=0x11 only.
- out_ready=0, send 0x01..0x05 -> FIFO holds 0x01..0x04; overrun pulses once on 0x05; draining yields 0x01,0x02,0x03,0x04.
- FIFO full and out_ready=1 during the stop sample of 0x06 -> no overrun; 0x06 is accepted after 0x02..0x04.
- Assert reset during bit 3 of 0x55 while FIFO holds one byte -> out_valid=0, rx_busy=0 next cycle; a following 0x77 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> out_data=0x07; send 0x07 with parity 0 -> frame_err pulse, no push.
